// File: rtl/mem_io_bridge_pkg.sv
// ============================================================================
// Module   : mem_io_bridge_pkg
// Brief    : Shared address map, state and read-select types for mem_io_bridge
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_io_bridge_pkg;

    localparam logic [17:0] IO_UART_ADDR = 18'h30000;
    localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
    localparam logic [1:0]  IO_SEL       = 2'b11;
    localparam int          RAM_AW       = 17;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } bridge_state_t;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_RX   = 2'd2,
        SEL_SNAP = 2'd3
    } rd_sel_t;

endpackage

`default_nettype wire

// File: rtl/mem_io_bridge_fifo.sv
// ============================================================================
// Module   : bridge_fifo
// Brief    : Synchronous FIFO with count/full/empty; push into a full FIFO is
//            accepted only when a pop frees the slot in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bridge_fifo #(
    parameter int DEPTH_LOG = 4,
    parameter int WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     pop_data,
    output logic [DEPTH_LOG:0]   count,
    output logic [DEPTH_LOG:0]   count_next,
    output logic                 full,
    output logic                 empty
);

    localparam logic [DEPTH_LOG:0] c_depth = (DEPTH_LOG+1)'(1 << DEPTH_LOG);

    logic [WIDTH-1:0]     r_mem [1 << DEPTH_LOG];
    logic [DEPTH_LOG-1:0] r_wr_ptr;
    logic [DEPTH_LOG-1:0] r_rd_ptr;
    logic [DEPTH_LOG:0]   r_count;
    logic                 w_pop;
    logic                 w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == c_depth);
    assign count  = r_count;
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    // Head is masked while empty so the output reads zero out of reset.
    assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

    always_comb begin
        count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   count_next = r_count + 1'b1;
            2'b01:   count_next = r_count - 1'b1;
            default: count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/mem_io_bridge.sv
// ============================================================================
// Module   : mem_io_bridge
// Brief    : CPU byte-port bridge to block RAM and memory-mapped I/O (UART TX
//            FIFO, optional UART RX, cycle counter, program stop).
//            Optional RX path enabled by defining MEM_IO_BRIDGE_RX_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_io_bridge
    import mem_io_bridge_pkg::*;
#(
    parameter int TX_DEPTH_LOG = 4,
    parameter int FULL_MARGIN  = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic [31:0]         cpu_a,
    input  logic [7:0]          cpu_dout,
    input  logic                cpu_wr,
    output logic [7:0]          cpu_din,
    output logic                io_buffer_full,
    output logic [RAM_AW-1:0]   ram_a,
    output logic [7:0]          ram_dout,
    output logic                ram_we,
    input  logic [7:0]          ram_din,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_pop,
    output logic                halted
);

    localparam logic [TX_DEPTH_LOG:0] c_full_thresh =
        (TX_DEPTH_LOG+1)'((1 << TX_DEPTH_LOG) - FULL_MARGIN);

    bridge_state_t         r_state;
    rd_sel_t               r_rd_sel;
    rd_sel_t               w_rd_sel;
    logic [1:0]            r_byte_sel;
    logic [31:0]           r_cycle_cnt;
    logic [31:0]           r_snapshot;
    logic [7:0]            r_rx_byte;

    logic                  w_io;
    logic [17:0]           w_addr;
    logic                  w_run;
    logic                  w_wr_ok;
    logic                  w_rd;
    logic                  w_uart_hit;
    logic                  w_clk_hit;
    logic                  w_stop;
    logic                  w_push;
    logic [7:0]            w_push_data;
    logic                  w_empty;
    logic                  w_full;
    logic [TX_DEPTH_LOG:0] w_count;
    logic [TX_DEPTH_LOG:0] w_count_next;

    assign w_addr     = cpu_a[17:0];
    assign w_io       = (cpu_a[17:16] == IO_SEL);
    assign w_run      = (r_state == RUN);
    assign w_wr_ok    = cpu_wr & rdy_in & w_run;
    assign w_rd       = ~cpu_wr & rdy_in;
    assign w_uart_hit = (w_addr == IO_UART_ADDR);
    assign w_clk_hit  = (w_addr[17:2] == IO_CLK_ADDR[17:2]);
    assign w_stop     = w_wr_ok & (w_addr == IO_CLK_ADDR);

    // Zero bytes are the stop marker on the wire, so plain UART writes of 0 are dropped.
    assign w_push      = (w_wr_ok & w_uart_hit & (cpu_dout != 8'h00)) | w_stop;
    assign w_push_data = w_stop ? 8'h00 : cpu_dout;

    // RAM port is combinational so ram_din lines up with the next cycle; held at zero in reset.
    assign ram_a    = rst_in ? cpu_a[RAM_AW-1:0] : '0;
    assign ram_dout = rst_in ? cpu_dout : 8'h00;
    assign ram_we   = rst_in & cpu_wr & rdy_in & ~w_io & w_run;

    assign tx_valid = ~w_empty;

    bridge_fifo #(
        .DEPTH_LOG (TX_DEPTH_LOG),
        .WIDTH     (8)
    ) u_tx_fifo (
        .clk        (clk_in),
        .rst_n      (rst_in),
        .push       (w_push),
        .push_data  (w_push_data),
        .pop        (tx_ready),
        .pop_data   (tx_data),
        .count      (w_count),
        .count_next (w_count_next),
        .full       (w_full),
        .empty      (w_empty)
    );

    always_comb begin
        w_rd_sel = SEL_ZERO;
        if (!cpu_wr) begin
            if (!w_io)          w_rd_sel = SEL_RAM;
            else if (w_uart_hit) w_rd_sel = SEL_RX;
            else if (w_clk_hit)  w_rd_sel = SEL_SNAP;
            else                 w_rd_sel = SEL_ZERO;
        end
    end

    always_comb begin
        cpu_din = 8'h00;
        case (r_rd_sel)
            SEL_RAM:  cpu_din = ram_din;
            SEL_RX:   cpu_din = r_rx_byte;
            SEL_SNAP: cpu_din = r_snapshot[8*r_byte_sel +: 8];
            default:  cpu_din = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state        <= RUN;
            halted         <= 1'b0;
            r_rd_sel       <= SEL_ZERO;
            r_byte_sel     <= 2'd0;
            r_cycle_cnt    <= 32'd0;
            r_snapshot     <= 32'd0;
            io_buffer_full <= 1'b0;
        end else begin
            io_buffer_full <= (w_count_next >= c_full_thresh);
            if (rdy_in) begin
                r_rd_sel   <= w_rd_sel;
                r_byte_sel <= cpu_a[1:0];
                if (r_state != HALTED)
                    r_cycle_cnt <= r_cycle_cnt + 32'd1;
                if (w_rd & w_clk_hit & (cpu_a[1:0] == 2'd0))
                    r_snapshot <= r_cycle_cnt;
                case (r_state)
                    RUN: begin
                        if (w_stop) r_state <= DRAIN;
                    end
                    DRAIN: begin
                        if (w_empty & ~(tx_valid & tx_ready)) begin
                            r_state <= HALTED;
                            halted  <= 1'b1;
                        end
                    end
                    HALTED: begin
                        halted <= 1'b1;
                    end
                    default: r_state <= RUN;
                endcase
            end
        end
    end

`ifdef MEM_IO_BRIDGE_RX_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_pop    <= 1'b0;
            r_rx_byte <= 8'h00;
        end else if (rdy_in) begin
            rx_pop    <= w_rd & w_uart_hit & rx_valid;
            r_rx_byte <= (w_rd & w_uart_hit & rx_valid) ? rx_data : 8'h00;
        end else begin
            rx_pop <= 1'b0;
        end
    end

    logic w_unused;
    assign w_unused = ^{cpu_a[31:18], w_count, w_full};
`else
    assign rx_pop    = 1'b0;
    assign r_rx_byte = 8'h00;

    logic w_unused;
    assign w_unused = ^{cpu_a[31:18], w_count, w_full, rx_data, rx_valid};
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_io_bridge.sv
// ============================================================================
// Module   : tb_mem_io_bridge
// Brief    : Directed self-checking bench for mem_io_bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_io_bridge;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        halted;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  txq [$];
    logic [7:0]  ram_mem [0:131071];
    logic [31:0] mcnt;
    logic [31:0] exp_cnt;

    always #5 clk_in = ~clk_in;

    mem_io_bridge dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .cpu_a          (cpu_a),
        .cpu_dout       (cpu_dout),
        .cpu_wr         (cpu_wr),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_dout       (ram_dout),
        .ram_we         (ram_we),
        .ram_din        (ram_din),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_pop         (rx_pop),
        .halted         (halted)
    );

    // Block RAM with one-cycle read latency.
    always @(posedge clk_in) begin
        if (ram_we) ram_mem[ram_a] <= ram_dout;
        ram_din <= ram_mem[ram_a];
    end

    always @(negedge clk_in) begin
        if (rst_in && tx_valid && tx_ready) txq.push_back(tx_data);
    end

    // Reference cycle counter, valid while the bridge is not halted.
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)     mcnt <= 32'd0;
        else if (rdy_in) mcnt <= mcnt + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [7:0] d);
        cpu_a = a; cpu_dout = d; cpu_wr = 1'b1;
        tick();
        cpu_a = 32'd0; cpu_dout = 8'h00; cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a);
        cpu_a = a; cpu_wr = 1'b0;
        tick();
        cpu_a = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 131072; i++) ram_mem[i] = 8'h00;
        rst_in = 1'b0; rdy_in = 1'b1; cpu_a = 32'h0000_0123; cpu_wr = 1'b1;
        cpu_dout = 8'h5C; tx_ready = 1'b0; rx_data = 8'h5A; rx_valid = 1'b0;
        repeat (3) tick();
        chk("rst_cpu_din", cpu_din, 0);
        chk("rst_io_full", io_buffer_full, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_a", ram_a, 0);
        chk("rst_ram_dout", ram_dout, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rx_pop", rx_pop, 0);
        chk("rst_halted", halted, 0);
        cpu_wr = 1'b0; cpu_a = 32'd0; cpu_dout = 8'h00;
        rst_in = 1'b1;
        tick();

        // RAM write/read
        cpu_a = 32'h100; cpu_dout = 8'hA5; cpu_wr = 1'b1;
        #1;
        chk("ram_we_wr", ram_we, 1);
        chk("ram_a_wr", ram_a, 17'h100);
        chk("ram_dout_wr", ram_dout, 8'hA5);
        tick();
        cpu_read(32'h100);
        chk("ram_rd_100", cpu_din, 8'hA5);
        cpu_write(32'h1FFFF, 8'h3C);
        cpu_read(32'h1FFFF);
        chk("ram_rd_top", cpu_din, 8'h3C);
        rdy_in = 1'b0; cpu_a = 32'h200; cpu_dout = 8'h77; cpu_wr = 1'b1;
        #1;
        chk("ram_we_rdy_low", ram_we, 0);
        tick();
        rdy_in = 1'b1; cpu_wr = 1'b0;
        cpu_read(32'h200);
        chk("ram_rd_rdy_low", cpu_din, 8'h00);
        cpu_write(32'h10, 8'h99);
        cpu_read(32'h30010);
        chk("io_unmapped_rd", cpu_din, 8'h00);

        // UART TX with zero-drop
        tx_ready = 1'b1; txq.delete();
        cpu_write(32'h30000, 8'h48);
        cpu_write(32'h30000, 8'h69);
        cpu_write(32'h30000, 8'h00);
        repeat (5) tick();
        chk("uart_cnt", txq.size(), 2);
        if (txq.size() >= 2) begin
            chk("uart_b0", txq[0], 8'h48);
            chk("uart_b1", txq[1], 8'h69);
        end
        chk("uart_idle_valid", tx_valid, 0);

        // Back-pressure
        tx_ready = 1'b0; txq.delete();
        for (int i = 1; i <= 14; i++) begin
            cpu_write(32'h30000, 8'(i));
            if (i == 1) begin
                chk("push_tx_valid", tx_valid, 1);
                chk("push_tx_data", tx_data, 8'h01);
            end
            if (i == 13) chk("full_at_13", io_buffer_full, 0);
        end
        tick();
        chk("full_at_14", io_buffer_full, 1);
        for (int i = 15; i <= 17; i++) cpu_write(32'h30000, 8'(i));
        tx_ready = 1'b1;
        for (int k = 0; k < 40 && tx_valid; k++) tick();
        repeat (2) tick();
        chk("bp_drained_cnt", txq.size(), 16);
        if (txq.size() == 16) begin
            chk("bp_first", txq[0], 8'h01);
            chk("bp_last", txq[15], 8'h10);
        end
        chk("bp_full_clear", io_buffer_full, 0);

        // Cycle counter snapshot
        rdy_in = 1'b0;
        repeat (4) tick();
        rdy_in = 1'b1;
        repeat (300) tick();
        cpu_a = 32'h30004; cpu_wr = 1'b0;
        exp_cnt = mcnt;
        tick();
        cpu_a = 32'd0;
        chk("cnt_b0", cpu_din, {24'd0, exp_cnt[7:0]});
        repeat (7) tick();
        cpu_read(32'h30005);
        chk("cnt_b1", cpu_din, {24'd0, exp_cnt[15:8]});
        repeat (3) tick();
        cpu_read(32'h30006);
        chk("cnt_b2", cpu_din, {24'd0, exp_cnt[23:16]});
        cpu_read(32'h30007);
        chk("cnt_b3", cpu_din, {24'd0, exp_cnt[31:24]});

        // UART RX
        rx_valid = 1'b1; rx_data = 8'h5A;
        cpu_read(32'h30000);
        rx_valid = 1'b0;
`ifdef MEM_IO_BRIDGE_RX_EN
        chk("rx_data", cpu_din, 8'h5A);
        chk("rx_pop_pulse", rx_pop, 1);
        tick();
        chk("rx_pop_end", rx_pop, 0);
`else
        chk("rx_off_data", cpu_din, 8'h00);
        chk("rx_off_pop", rx_pop, 0);
`endif
        cpu_read(32'h30000);
        chk("rx_empty_data", cpu_din, 8'h00);

        // Program stop and drain
        tx_ready = 1'b0; txq.delete();
        cpu_write(32'h30000, 8'h11);
        cpu_write(32'h30000, 8'h22);
        cpu_write(32'h30000, 8'h33);
        cpu_write(32'h30004, 8'h77);
        cpu_a = 32'h300; cpu_dout = 8'hEE; cpu_wr = 1'b1;
        #1;
        chk("drain_ram_we", ram_we, 0);
        tick();
        cpu_write(32'h30000, 8'h55);
        chk("drain_halted", halted, 0);
        tx_ready = 1'b1;
        for (int k = 0; k < 30 && tx_valid; k++) tick();
        chk("drain_empty", tx_valid, 0);
        chk("halt_not_yet", halted, 0);
        tick();
        chk("halt_set", halted, 1);
        chk("halt_tx_cnt", txq.size(), 4);
        if (txq.size() == 4) begin
            chk("halt_b0", txq[0], 8'h11);
            chk("halt_b1", txq[1], 8'h22);
            chk("halt_b2", txq[2], 8'h33);
            chk("halt_b3", txq[3], 8'h00);
        end
        cpu_a = 32'h300; cpu_dout = 8'hEE; cpu_wr = 1'b1;
        #1;
        chk("halt_ram_we", ram_we, 0);
        tick();
        cpu_wr = 1'b0;
        cpu_read(32'h300);
        chk("halt_ram_rd", cpu_din, 8'h00);
        repeat (3) tick();
        chk("halt_sticky", halted, 1);

        // Reset during drain
        rst_in = 1'b0; tick(); rst_in = 1'b1; tick();
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) cpu_write(32'h30000, 8'(8'hA0 + i));
        cpu_write(32'h30004, 8'h00);
        tick();
        chk("pre_rst_valid", tx_valid, 1);
        rst_in = 1'b0;
        #1;
        chk("rst_mid_valid", tx_valid, 0);
        chk("rst_mid_halted", halted, 0);
        tick();
        rst_in = 1'b1;
        tick();
        cpu_a = 32'h400; cpu_dout = 8'h42; cpu_wr = 1'b1;
        #1;
        chk("post_rst_ram_we", ram_we, 1);
        tick();
        cpu_wr = 1'b0;
        cpu_write(32'h30000, 8'h61);
        chk("post_rst_tx_valid", tx_valid, 1);
        chk("post_rst_tx_data", tx_data, 8'h61);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_io_bridge.md
# mem_io_bridge

Memory/IO bridge directly downstream of the CPU core's byte-wide memory port. It decodes each CPU access into either the 128 KB block RAM or the memory-mapped I/O space (`mem_a[17:16]==2'b11`). The I/O space holds a UART TX FIFO, an optional UART RX path, a free-running cycle counter and the program-stop mechanism. The bridge returns read data with the fixed one-cycle latency the core expects and drives the core's `io_buffer_full` back-pressure.

## Interface
Parameters:
- `TX_DEPTH_LOG`, 4, log2 of TX FIFO entries (16).
- `FULL_MARGIN`, 2, free entries below which `io_buffer_full` asserts.

Ports:
- `clk_in`  input  1  system clock. One clock domain only.
- `rst_in`  input  1  reset, asynchronous and active-low.
- `rdy_in`  input  1  global ready. When low, no RAM access, FIFO push or counter snapshot occurs.
- `cpu_a`  input  32  CPU address; only bits 17:0 are decoded.
- `cpu_dout`  input  8  CPU write data.
- `cpu_wr`  input  1  1 = write, 0 = read.
- `cpu_din`  output  8  read data, valid the cycle after the read address.
- `io_buffer_full`  output  1  TX FIFO nearly full.
- `ram_a`  output  17  block RAM address.
- `ram_dout`  output  8  block RAM write data.
- `ram_we`  output  1  block RAM write enable.
- `ram_din`  input  8  block RAM read data, one-cycle latency.
- `tx_data`  output  8  UART TX byte.
- `tx_valid`  output  1  TX byte available.
- `tx_ready`  input  1  UART accepts the byte this cycle.
- `rx_data`  input  8  UART RX byte (only with RX enabled).
- `rx_valid`  input  1  RX byte available.
- `rx_pop`  output  1  consume RX byte, one-cycle pulse.
- `halted`  output  1  program finished; sticky.

## Operation
- Decode: I/O when `cpu_a[17:16]==2'b11`, otherwise RAM (`ram_a = cpu_a[16:0]`, `ram_we = cpu_wr & rdy_in & ~io & state==RUN`).
- Write 0x30000: push `cpu_dout` to TX FIFO. A value of 0x00 is dropped.
- Write 0x30004: push 0x00 to the FIFO, then state RUN→DRAIN.
- Read 0x30000: returns `rx_data` and pulses `rx_pop` when `rx_valid`; returns 0x00 if no byte is available.
- Read 0x30004..0x30007: returns byte `cpu_a[1:0]` of the cycle counter. A read of 0x30004 latches the full 32-bit counter into a snapshot register, and all four bytes come from that snapshot.
- Other I/O addresses read 0x00; writes to them are ignored.
- Cycle counter: 32-bit, increments each `clk_in` while `rdy_in` is high and state≠HALTED, wraps 0xFFFFFFFF→0.
- Read mux select is registered alongside the address. `cpu_din` selects `ram_din`, RX or snapshot byte for the previous cycle's access.
- State machine:
  - RUN: normal operation.
  - DRAIN: CPU writes are ignored. Leave for HALTED when the FIFO is empty and no TX handshake is in progress.
  - HALTED: terminal; `halted=1`; only reset leaves it.
- TX FIFO: `tx_valid = ~empty`. A pop happens on `tx_valid & tx_ready`. A push when full is dropped.
- Simultaneous push and pop: the count is unchanged. This is legal when full (the pop frees the slot first) and when empty (the push proceeds; the pop is impossible since `tx_valid=0`).
- `io_buffer_full = count >= 2**TX_DEPTH_LOG - FULL_MARGIN`. It is registered and updated every cycle.

## Timing
- Reset values:
  - `cpu_din=0`, `io_buffer_full=0`, `ram_we=0`, `ram_a=0`, `ram_dout=0`.
  - `tx_valid=0`, `tx_data=0`, `rx_pop=0`, `halted=0`.
  - Counter 0, snapshot 0, FIFO empty, state RUN.
- Read latency is exactly 1 cycle for both RAM and I/O.
- Writes take effect at the clock edge of the write cycle.
- FIFO push→`tx_valid` takes 1 cycle.
- `rdy_in` low freezes all registers except the FIFO pop side; the UART keeps draining.
- Reset asserted mid-drain discards FIFO contents immediately.

## Configuration
- `MEM_IO_BRIDGE_RX_EN` defined: UART RX path is live as described.
- Not defined: `rx_pop` is tied 0, reads of 0x30000 return 0x00, and `rx_data`/`rx_valid` are unused.

## Structure
- Shared package holds:
  - address constants `IO_UART_ADDR=18'h30000`, `IO_CLK_ADDR=18'h30004`, `IO_SEL=2'b11`;
  - the state enum RUN/DRAIN/HALTED;
  - `RAM_AW=17`.
- One sub-module: `bridge_fifo`, a parameterised synchronous FIFO with count, full and empty outputs, instantiated for TX.

## Test plan
- RAM: write 0xA5 to 0x00100, read 0x00100 next cycle → `cpu_din=0xA5` exactly one cycle after the read.
- UART: write 'H','i',0x00 to 0x30000 with `tx_ready=1` → `tx_data` sequence 0x48, 0x69 only; the 0x00 never appears.
- Back-pressure: hold `tx_ready=0` and push 14 bytes → `io_buffer_full=1` after the 14th push. Push 3 more → only 2 are stored (count 16) and the last is dropped.
- Counter: at counter=0x12345678 read 0x30004, then 0x30005..0x30007 over later cycles → bytes 0x78, 0x56, 0x34, 0x12 from the snapshot.
- Halt: 3 bytes queued, write 0x30004, `tx_ready=1` → 3 bytes then 0x00 transmitted; `halted=1` the cycle after the FIFO empties; later RAM writes are ignored.
- Reset: assert `rst_in=0` during DRAIN with 5 bytes queued → `tx_valid=0` and `halted=0` immediately; state RUN after release.
